// File: rtl/layers_sched.sv
// layers_sched: job-level sequencer for the layers datapath.
// Takes one job descriptor and issues the layers config write. It then gates
// the image stream, marking the last beat of each kernel pass, and counts
// pooled results until the job is complete.
module layers_sched #(
  parameter int                    CFG_DWIDTH      = 32,
  parameter int                    CFG_AWIDTH      = 5,
  parameter logic [CFG_AWIDTH-1:0] CFG_LAYERS_ADDR = 5'd3,
  parameter int                    GROUP_NB        = 4,
  parameter int                    IMG_WIDTH       = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [15:0]                   job_len,
  input  logic [7:0]                    job_pool,
  input  logic [15:0]                   job_out,
  input  logic                          job_bypass,
  input  logic [7:0]                    job_shift,
  input  logic [7:0]                    job_head,
  input  logic                          job_val,
  output logic                          job_rdy,
  input  logic [GROUP_NB*IMG_WIDTH-1:0] src_data,
  input  logic                          src_val,
  output logic                          src_rdy,
  output logic [CFG_DWIDTH-1:0]         cfg_data,
  output logic [CFG_AWIDTH-1:0]         cfg_addr,
  output logic                          cfg_valid,
  output logic [GROUP_NB*IMG_WIDTH-1:0] image,
  output logic                          image_last,
  output logic                          image_val,
  input  logic                          image_rdy,
  input  logic                          result_val,
  input  logic                          result_rdy,
  output logic                          busy,
  output logic                          done
);

  typedef enum logic [5:0] {
    IDLE   = 6'b000001,
    CFG    = 6'b000010,
    SETTLE = 6'b000100,
    STREAM = 6'b001000,
    DRAIN  = 6'b010000,
    DONE   = 6'b100000
  } state_t;

  state_t      state;
  logic [15:0] len_r, out_r, beat_cnt, res_cnt;
  logic [7:0]  pool_r;
  logic [23:0] total_r, pass_cnt;
  logic        settle;

  logic streaming, beat_acc, res_hs;

  // Stream gating is combinational so a beat costs no extra latency.
  assign streaming  = (state == STREAM);
  assign image      = streaming ? src_data : '0;
  assign image_val  = streaming & src_val;
  assign src_rdy    = streaming & image_rdy;
  assign image_last = streaming & (beat_cnt == len_r - 16'd1);
  assign beat_acc   = streaming & src_val & image_rdy;
  assign res_hs     = result_val & result_rdy;

  // Job FSM with registered control outputs, beat/pass/result counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      job_rdy   <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      cfg_valid <= 1'b0;
      cfg_data  <= '0;
      cfg_addr  <= '0;
      len_r     <= '0;
      out_r     <= '0;
      pool_r    <= '0;
      total_r   <= '0;
      beat_cnt  <= '0;
      pass_cnt  <= '0;
      res_cnt   <= '0;
      settle    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (job_val) begin
          // A zero length would never mark a pass end, so treat it as 1.
          len_r     <= (job_len == 16'd0) ? 16'd1 : job_len;
          out_r     <= job_out;
          pool_r    <= job_pool;
          beat_cnt  <= '0;
          pass_cnt  <= '0;
          res_cnt   <= '0;
          cfg_valid <= 1'b1;
          cfg_addr  <= CFG_LAYERS_ADDR;
          cfg_data  <= CFG_DWIDTH'({7'b0, job_bypass, job_pool, job_shift, job_head});
          job_rdy   <= 1'b0;
          busy      <= 1'b1;
          state     <= CFG;
        end
        CFG: begin
          cfg_valid <= 1'b0;
          cfg_addr  <= '0;
          cfg_data  <= '0;
          total_r   <= 24'(out_r) * (24'(pool_r) + 24'd1);
          settle    <= 1'b0;
          if (out_r == 16'd0) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            state <= SETTLE;
          end
        end
        // Two cycles for layers to register its new configuration.
        SETTLE: if (settle) state <= STREAM;
                else        settle <= 1'b1;
        STREAM: if (beat_acc) begin
          if (image_last) begin
            beat_cnt <= '0;
            pass_cnt <= pass_cnt + 24'd1;
            if (pass_cnt == total_r - 24'd1) state <= DRAIN;
          end else begin
            beat_cnt <= beat_cnt + 16'd1;
          end
        end
        DRAIN: if (res_cnt == out_r) begin
          done  <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          job_rdy <= 1'b1;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
      // Results may arrive any time after acceptance, including alongside the final beat.
      if (state != IDLE && res_hs && res_cnt != out_r) res_cnt <= res_cnt + 16'd1;
    end
  end

endmodule

// File: doc/layers_sched.md
Name: layers_sched

Overview:
- Job-level sequencer for the layers datapath (group MAC -> add -> pool -> ReLU -> rescale).
- Accepts one job descriptor, then issues the matching CFG_LAYERS configuration write.
- Gates the upstream image stream into the layers block, marking image_last on every kernel-pass boundary.
- Counts pooled results leaving layers and signals job completion. Sits between the image buffer/DMA and the layers instance.

Parameters:
- CFG_DWIDTH, 32, config bus data width.
- CFG_AWIDTH, 5, config bus address width.
- CFG_LAYERS_ADDR, 5'd3, config address of the layers register.
- GROUP_NB, 4, image words per beat.
- IMG_WIDTH, 16, image word width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- job_len  in  16  beats per kernel pass (MAC accumulation length).
- job_pool  in  8  pool_nb; passes per result = job_pool+1.
- job_out  in  16  results in the job.
- job_bypass  in  1  ReLU bypass.
- job_shift  in  8  rescale shift.
- job_head  in  8  rescale head.
- job_val  in  1  descriptor valid.
- job_rdy  out  1  descriptor accepted.
- src_data  in  GROUP_NB*IMG_WIDTH  upstream image beat.
- src_val  in  1  upstream valid.
- src_rdy  out  1  upstream ready.
- cfg_data  out  CFG_DWIDTH  config write data.
- cfg_addr  out  CFG_AWIDTH  config write address.
- cfg_valid  out  1  config write strobe.
- image  out  GROUP_NB*IMG_WIDTH  to layers.
- image_last  out  1  final beat of a kernel pass.
- image_val  out  1  to layers.
- image_rdy  in  1  from layers.
- result_val  in  1  layers result valid (snooped).
- result_rdy  in  1  downstream ready (snooped).
- busy  out  1  job in progress.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset (rst_n=0 at clk edge): state IDLE, all counters 0, outputs held as follows.
  - job_rdy=1; busy=0; done=0; cfg_valid=0; src_rdy=0; image_val=0; image_last=0.
  - cfg_data=0; cfg_addr=0.
- A reset asserted mid-job abandons the job in the same edge; no done pulse. Layers must be reset alongside it.
- FSM states: IDLE, CFG, SETTLE, STREAM, DRAIN, DONE (one-hot).
- IDLE:
  - job_rdy=1.
  - On job_val: latch all job_* fields. Effective len = max(job_len,1).
  - Go to CFG; job_rdy deasserts the next cycle.
- CFG (exactly 1 cycle):
  - cfg_valid=1, cfg_addr=CFG_LAYERS_ADDR.
  - cfg_data = {7'b0, bypass, pool, shift, head}; bits [24],[23:16],[15:8],[7:0].
  - If out==0, go to DONE; else go to SETTLE.
- SETTLE: 2 cycles (config registered in layers), then STREAM.
- STREAM:
  - Combinational pass-through: image=src_data, image_val=src_val, src_rdy=image_rdy.
  - Beat accepted when src_val & image_rdy.
  - beat_cnt increments per accepted beat. image_last=1 when beat_cnt==len-1; on that beat beat_cnt clears to 0 and pass_cnt increments.
  - Total passes = out*(pool+1), computed as a 24-bit product at CFG.
  - The accepted last beat of the final pass moves to DRAIN; src_rdy=0 and image_val=0 from the next cycle.
- DRAIN: wait until res_cnt==out, then go to DONE.
- res_cnt:
  - Increments on result_val & result_rdy in any non-IDLE state.
  - Saturates at out.
  - A result handshake coinciding with the final image beat is counted.
- DONE (1 cycle): done=1, then IDLE.
- busy=1 in all states except IDLE.
- job_val while busy is ignored (job_rdy=0).
- Counter widths: beat_cnt 16, pass_cnt 24, res_cnt 16. No wrap within legal ranges.
- Latency:
  - job_val accepted -> cfg_valid: 1 cycle.
  - job_val accepted -> first possible image beat: 4 cycles.
  - Last result handshake -> done: 2 cycles (DRAIN detects, DONE asserts).

Test Plan:
- len=4, pool=0, out=2, bypass=1, shift=2, head=3:
  - cfg_data=0x01000203 once at CFG_LAYERS_ADDR.
  - Exactly 8 beats pass, with image_last on beats 4 and 8.
  - done fires 2 cycles after the 2nd result handshake.
- len=3, pool=3, out=1:
  - 12 beats with last every 3rd beat; src_rdy=0 after beat 12.
  - done only after 1 result.
- Randomly toggle image_rdy and src_val on len=5, pool=1, out=3:
  - No beat is lost or duplicated; 30 beats total; last markers at 5, 10, …, 30.
- out=0: CFG pulse, then done 1 cycle later; no src_rdy assertion ever.
- len=0, pool=0, out=2: treated as len=1, so every beat has image_last=1; 2 beats total.
- rst_n low during STREAM after 7 of 16 beats:
  - Next cycle is IDLE, job_rdy=1, no done.
  - A new job len=2, pool=0, out=1 then completes normally.
